// File: rtl/ctrl_pkt_fifo_pkg.sv
// Default geometry for the control-path packet FIFO.
package ctrl_pkt_fifo_pkg;

   localparam int DFLT_DATA_W     = 32;
   localparam int DFLT_PKT_WORDS  = 16;
   localparam int DFLT_DEPTH_PKTS = 4;

endpackage

// File: rtl/ctrl_pkt_fifo_ram.sv
// Simple dual-port word store: synchronous write, asynchronous (show-ahead) read.
module ctrl_pkt_fifo_ram #(
   parameter int DATA_W = 32,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**AW];

   // Write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_pkt_fifo.sv
// Packet-gated command FIFO: words become visible to the CPU only once their
// whole packet has been written. A packet that hits a full buffer is dropped
// in its entirety and flagged on the sticky ovf output.
module ctrl_pkt_fifo
   import ctrl_pkt_fifo_pkg::*;
#(
   parameter int DATA_W     = DFLT_DATA_W,
   parameter int PKT_WORDS  = DFLT_PKT_WORDS,
   parameter int DEPTH_PKTS = DFLT_DEPTH_PKTS
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               sclr,
   input  logic [DATA_W-1:0]                  wr_data,
   input  logic                               wr_en,
   output logic                               wr_full,
   output logic [DATA_W-1:0]                  rd_data,
   input  logic                               rd_en,
   output logic                               rd_empty,
   output logic [$clog2(DEPTH_PKTS+1)-1:0]    pkt_cnt,
   output logic                               ovf
);

   localparam int DEPTH = PKT_WORDS * DEPTH_PKTS;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH_PKTS + 1);
   localparam int PW    = $clog2(PKT_WORDS);

   logic [AW:0]   wp_q, wp_d, cp_q, cp_d, rp_q, rp_d;
   logic [PW-1:0] wcnt_q, wcnt_d;
   logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
   logic          drop_q, drop_d, ovf_q, ovf_d;
   logic          ram_we;
   logic          rd_go, wr_store, pkt_inc, pkt_dec;
   logic [AW:0]   wp_next;

   assign wr_full  = ((wp_q - rp_q) == (AW+1)'(DEPTH));
   assign rd_empty = (rp_q == cp_q);
   assign pkt_cnt  = pkt_cnt_q;
   assign ovf      = ovf_q;

   // Next-state: flush first, then independent read and write/commit paths.
   always_comb begin
      wp_d      = wp_q;
      cp_d      = cp_q;
      rp_d      = rp_q;
      wcnt_d    = wcnt_q;
      pkt_cnt_d = pkt_cnt_q;
      drop_d    = drop_q;
      ovf_d     = ovf_q;
      ram_we    = 1'b0;
      rd_go     = 1'b0;
      wr_store  = 1'b0;
      pkt_inc   = 1'b0;
      pkt_dec   = 1'b0;
      wp_next   = wp_q;

      if (sclr) begin
         wp_d      = '0;
         cp_d      = '0;
         rp_d      = '0;
         wcnt_d    = '0;
         pkt_cnt_d = '0;
         drop_d    = 1'b0;
         ovf_d     = 1'b0;
      end else begin
         rd_go = rd_en && !rd_empty;
         if (rd_go) begin
            rp_d    = rp_q + (AW+1)'(1);
            pkt_dec = (rp_q[PW-1:0] == PW'(PKT_WORDS-1));
         end

         if (wr_en) begin
            // Full test uses pre-cycle pointers, so a same-cycle read cannot rescue the word.
            wr_store = !wr_full && !drop_q;
            ram_we   = wr_store;
            wp_next  = wr_store ? wp_q + (AW+1)'(1) : wp_q;
            if (wr_full) ovf_d = 1'b1;

            if (wcnt_q == PW'(PKT_WORDS-1)) begin
               wcnt_d = '0;
               drop_d = 1'b0;
               if (drop_q || wr_full) begin
                  wp_d = cp_q;
               end else begin
                  wp_d    = wp_next;
                  cp_d    = wp_next;
                  pkt_inc = 1'b1;
               end
            end else begin
               wcnt_d = wcnt_q + PW'(1);
               wp_d   = wp_next;
               drop_d = drop_q || wr_full;
            end
         end

         pkt_cnt_d = pkt_cnt_q + CW'(pkt_inc) - CW'(pkt_dec);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp_q      <= '0;
         cp_q      <= '0;
         rp_q      <= '0;
         wcnt_q    <= '0;
         pkt_cnt_q <= '0;
         drop_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wp_q      <= wp_d;
         cp_q      <= cp_d;
         rp_q      <= rp_d;
         wcnt_q    <= wcnt_d;
         pkt_cnt_q <= pkt_cnt_d;
         drop_q    <= drop_d;
         ovf_q     <= ovf_d;
      end
   end

   ctrl_pkt_fifo_ram #(
      .DATA_W (DATA_W),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wp_q[AW-1:0]),
      .wdata (wr_data),
      .raddr (rp_q[AW-1:0]),
      .rdata (rd_data)
   );

endmodule
